imem_loader: RTL and testbench

- Write-side counterpart of the byte-wide instruction memory. It fills the memory before the datapath starts fetching.
- Accepts 32-bit instruction words over a valid/ready stream. Each word becomes four byte writes, MSB first, at ascending addresses. This matches the fetch concatenation {M[A], M[A+1], M[A+2], M[A+3]}.
- Sits between the testbench/boot source and the instruction memory's byte write port. Asserts done when the program image is in place.

---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_word_serializer.sv | 24 ++
 rtl/imem_loader.sv | 193 +++++++++++++++++++
 tb/tb_imem_loader.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory loader.
// Holds the loader FSM state enum, word/byte geometry and default depth.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    FINISH
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W = 2;
  localparam int MEM_BYTES_DEFAULT = 256;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: word stream in (valid/ready/word) and byte write port out.
// slave = loader side, master = boot source / memory side.
interface imem_loader_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport slave (
    input  in_valid,
    input  in_word,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output in_valid,
    output in_word,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/imem_word_serializer.sv
// imem_word_serializer: picks byte idx_i of word_i, MSB first (idx 0 = [31:24]).
// Ports: word_i, idx_i in; byte_o (data) and off_o (address offset) out.
module imem_word_serializer
  import imem_pkg::*;
(
  input  logic [31:0]           word_i,
  input  logic [BYTE_IDX_W-1:0] idx_i,
  output logic [7:0]            byte_o,
  output logic [BYTE_IDX_W-1:0] off_o
);

  always_comb begin
    byte_o = word_i[31:24];
    unique case (idx_i)
      2'd0: byte_o = word_i[31:24];
      2'd1: byte_o = word_i[23:16];
      2'd2: byte_o = word_i[15:8];
      2'd3: byte_o = word_i[7:0];
      default: byte_o = word_i[31:24];
    endcase
    off_o = idx_i;
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: turns a 32-bit word stream into MSB-first byte writes.
// Ports: clk, reset, start/base_addr/word_count, bus (stream + byte port),
// busy, done, error; checksum when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  imem_loader_if.slave     bus,
  output logic             busy,
  output logic             done,
  output logic             error
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  localparam logic [BYTE_IDX_W-1:0] K_LAST =
    BYTE_IDX_W'(BYTES_PER_WORD - 1);

  state_e                state_q, state_d;
  logic [63:0]           cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]      remaining_q, remaining_d;
  logic [31:0]           word_q, word_d;
  logic [BYTE_IDX_W-1:0] k_q, k_d;
  logic                  error_q, error_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [63:0]           mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]           csum_q, csum_d;
`endif

  logic                  xfer;
  logic                  oob;
  logic [7:0]            ser_byte;
  logic [BYTE_IDX_W-1:0] ser_off;

  // Serializer looks at the next-cycle word/index so the byte
  // port can be driven straight from flops.
  imem_word_serializer u_ser (
    .word_i (word_d),
    .idx_i  (k_d),
    .byte_o (ser_byte),
    .off_o  (ser_off)
  );

  assign xfer = bus.in_valid && in_ready_q;

  // 65-bit compare so a base near 2^64 cannot wrap past the check.
  assign oob = ({1'b0, cur_addr_q} + 65'd3) >= 65'(MEM_BYTES);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    k_d         = k_q;
    error_d     = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_addr_d  = base_addr;
          remaining_d = word_count;
          k_d         = '0;
          error_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d      = '0;
`endif
          if (base_addr[1:0] != 2'b00) begin
            error_d = 1'b1;
            state_d = FINISH;
          end else if (word_count == '0) begin
            state_d = FINISH;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      ACCEPT: begin
        if (xfer) begin
          if (oob) begin
            error_d = 1'b1;
            state_d = FINISH;
          end else begin
            word_d  = bus.in_word;
            k_d     = '0;
            state_d = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d  = csum_q + bus.in_word;
`endif
          end
        end
      end
      WRITE: begin
        if (k_q == K_LAST) begin
          k_d         = '0;
          cur_addr_d  = cur_addr_q + 64'(BYTES_PER_WORD);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = FINISH;
          end else begin
            state_d = ACCEPT;
          end
        end else begin
          k_d = k_q + BYTE_IDX_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output flops mirror the state being entered.
    in_ready_d = (state_d == ACCEPT);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FINISH);
    mem_we_d   = (state_d == WRITE);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (mem_we_d) begin
      mem_addr_d  = cur_addr_d + 64'(ser_off);
      mem_wdata_d = ser_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      k_q         <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      k_q         <= k_d;
      error_q     <= error_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed test of imem_loader byte sequencing and flags.
// Logs every byte write and checks cycle-level outputs.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] base_addr;
  logic [7:0]  word_count;
  logic        busy;
  logic        done;
  logic        error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  imem_loader_if bus ();

  imem_loader #(
    .MEM_BYTES (256),
    .CNT_W     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [63:0] log_a[$];
  logic [7:0]  log_d[$];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      log_a.push_back(bus.mem_addr);
      log_d.push_back(bus.mem_wdata);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] b,
                          input logic [7:0] c);
    start = 1'b1;
    base_addr = b;
    word_count = c;
    tick();
    start = 1'b0;
    base_addr = $urandom;
    word_count = 8'($urandom);
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_word = w;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_wait", 64'(n < 50), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_word = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic check_log(input string tag, input int m,
                           input int n, input logic [63:0] a0);
    check({tag, "_n"}, 64'(log_a.size() - m), 64'(n));
    for (int j = 0; j < n && m + j < log_a.size(); j++) begin
      check({tag, "_a"}, log_a[m+j], a0 + 64'(j));
    end
  endtask

  logic [7:0] exp2 [12] = '{
    8'h11, 8'h22, 8'h33, 8'h44,
    8'h55, 8'h66, 8'h77, 8'h88,
    8'h99, 8'hAA, 8'hBB, 8'hCC};
  logic [7:0] exp1 [4] = '{8'hF8, 8'h40, 8'h03, 8'hE0};
  logic [7:0] exp4 [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int m;
    int d0;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    bus.in_valid = 1'b0;
    bus.in_word = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_ready", 64'(bus.in_ready), 0);
    check("rst_we", 64'(bus.mem_we), 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", 64'(bus.mem_wdata), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_error", 64'(error), 0);

    // Single word, cycle-exact.
    do_start(64'd0, 8'd1);
    check("t1_busy", 64'(busy), 1);
    check("t1_ready", 64'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_word = 32'hF84003E0;
    tick();
    bus.in_valid = 1'b0;
    bus.in_word = $urandom;
    for (int k = 0; k < 4; k++) begin
      check("t1_we", 64'(bus.mem_we), 1);
      check("t1_ready_lo", 64'(bus.in_ready), 0);
      check("t1_addr", bus.mem_addr, 64'(k));
      check("t1_data", 64'(bus.mem_wdata), 64'(exp1[k]));
      tick();
    end
    check("t1_done", 64'(done), 1);
    check("t1_we_off", 64'(bus.mem_we), 0);
    check("t1_err", 64'(error), 0);
    tick();
    check("t1_done_lo", 64'(done), 0);
    check("t1_idle", 64'(busy), 0);

    // Three words at base 8 with gaps and held valid.
    m = log_a.size();
    do_start(64'd8, 8'd3);
    repeat (3) begin
      check("t2_starve", 64'(bus.mem_we), 0);
      tick();
    end
    send(32'h11223344);
    send(32'h55667788);
    repeat (4) tick();
    check("t2_starve2", 64'(bus.mem_we), 0);
    check("t2_ready2", 64'(bus.in_ready), 1);
    tick();
    check("t2_starve3", 64'(bus.mem_we), 0);
    send(32'h99AABBCC);
    wait_done("t2_done");
    check("t2_err", 64'(error), 0);
    check_log("t2", m, 12, 64'd8);
    for (int j = 0; j < 12 && m + j < log_d.size(); j++) begin
      check("t2_data", 64'(log_d[m+j]), 64'(exp2[j]));
    end
    tick();

    // Zero count.
    m = log_a.size();
    do_start(64'h40, 8'd0);
    check("t3_done", 64'(done), 1);
    check("t3_err", 64'(error), 0);
    tick();
    check("t3_idle", 64'(busy), 0);
    check("t3_nowr", 64'(log_a.size() - m), 0);

    // Misaligned base.
    m = log_a.size();
    do_start(64'd2, 8'd1);
    check("t3m_done", 64'(done), 1);
    check("t3m_err", 64'(error), 1);
    tick();
    check("t3m_sticky", 64'(error), 1);
    check("t3m_idle", 64'(busy), 0);
    check("t3m_nowr", 64'(log_a.size() - m), 0);

    // Bounds: second word at 256 is dropped.
    m = log_a.size();
    do_start(64'd252, 8'd2);
    check("t4_errclr", 64'(error), 0);
    send(32'hDEADBEEF);
    send(32'h01020304);
    check("t4_done", 64'(done), 1);
    check("t4_err", 64'(error), 1);
    check_log("t4", m, 4, 64'd252);
    for (int j = 0; j < 4 && m + j < log_d.size(); j++) begin
      check("t4_data", 64'(log_d[m+j]), 64'(exp4[j]));
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t4_csum", 64'(checksum), 64'hDEADBEEF);
`endif
    tick();
    do_start(64'h0, 8'd0);
    check("t4_err_cleared", 64'(error), 0);
    tick();

    // Reset during WRITE k=2.
    m = log_a.size();
    d0 = done_cnt;
    do_start(64'h20, 8'd2);
    send(32'hCAFEF00D);
    tick();
    tick();
    check("t5_k2", bus.mem_addr, 64'h22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_ready", 64'(bus.in_ready), 0);
    check("t5_we", 64'(bus.mem_we), 0);
    check("t5_addr", bus.mem_addr, 0);
    check("t5_wdata", 64'(bus.mem_wdata), 0);
    check("t5_busy", 64'(busy), 0);
    check("t5_done", 64'(done), 0);
    check("t5_error", 64'(error), 0);
    tick();
    check("t5_nodone", 64'(done_cnt - d0), 0);
    check_log("t5", m, 3, 64'h20);

    // Start while busy.
    m = log_a.size();
    do_start(64'h40, 8'd2);
    start = 1'b1;
    base_addr = 64'h80;
    word_count = 8'd5;
    tick();
    start = 1'b0;
    send(32'hA0B0C0D0);
    start = 1'b1;
    tick();
    start = 1'b0;
    send(32'h01234567);
    wait_done("t6_done");
    check("t6_err", 64'(error), 0);
    check_log("t6", m, 8, 64'h40);
    tick();
    check("t6_idle", 64'(busy), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_start(64'h0, 8'd2);
    check("t7_clr", 64'(checksum), 0);
    send(32'hFFFFFFFF);
    send(32'h00000002);
    wait_done("t7_done");
    check("t7_csum", 64'(checksum), 64'h1);
    tick();
    check("t7_hold", 64'(checksum), 64'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
